// File: rtl/l1_pmem_arbiter_pkg.sv
// Shared L1/L2 line-memory types and the client identifier used by the L1 memory arbiter.
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] pmem_L1_bus;
  typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} arb_client_t;

  function automatic arb_client_t other_client(input arb_client_t c);
    return (c == ICACHE) ? DCACHE : ICACHE;
  endfunction
endpackage

// File: rtl/l1_pmem_arb_checker.sv
// Protocol checks for the arbiter: exclusive dcache read/write and no L2 response without an open request.
module l1_pmem_arb_checker (
  input logic clk,
  input logic reset_n,
  input logic dcache_read,
  input logic dcache_write,
  input logic l2_resp,
  input logic l2_busy
);
  a_dcache_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(dcache_read && dcache_write));

  a_l2_resp_requested: assert property (@(posedge clk) disable iff (!reset_n)
    !(l2_resp && !l2_busy));
endmodule

// File: rtl/l1_pmem_arb_fsm.sv
// Arbitration sequencer: picks a client in IDLE, tracks the L2 round trip and the post-response drain cycle.
module l1_pmem_arb_fsm
  import lc3b_types::*;
#(
  parameter int unsigned RR_ENABLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        icache_req,
  input  logic        dcache_req,
  input  logic        l2_resp,
  output arb_client_t grant_o,
  output arb_client_t sel_o,
  output logic        load_o,
  output logic        done_o,
  output logic        busy_o
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } arb_state_t;

  arb_state_t  state_d, state_q;
  arb_client_t grant_d, grant_q;
  arb_client_t last_d, last_q;

  assign grant_o = grant_q;
  assign busy_o  = (state_q == S_ISSUE) || (state_q == S_WAIT);

  // Next-state, client selection and datapath load/capture strobes
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    sel_o   = grant_q;
    load_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (icache_req && dcache_req) begin
          if (RR_ENABLE != 32'd0) begin
            sel_o = other_client(last_q);
          end else begin
            sel_o = DCACHE;
          end
        end else if (dcache_req) begin
          sel_o = DCACHE;
        end else begin
          sel_o = ICACHE;
        end
        if (icache_req || dcache_req) begin
          load_o  = 1'b1;
          grant_d = sel_o;
          last_d  = sel_o;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      // a response already in the ISSUE cycle is handled exactly like one in WAIT
      S_ISSUE, S_WAIT: begin
        if (l2_resp) begin
          done_o  = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP:  state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, current grant and round-robin history registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= ICACHE;
      last_q  <= ICACHE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: rtl/l1_pmem_arbiter.sv
// L1 icache/dcache to L2 line-memory arbiter: serves one client at a time over a single L2 port.
module l1_pmem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned LINE_W    = 128,
  parameter int unsigned RR_ENABLE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] icache_address,
  input  logic              icache_read,
  output logic              icache_resp,
  output logic [LINE_W-1:0] icache_rdata,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic              dcache_resp,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);
  arb_client_t       grant, sel;
  logic              load, done, busy;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [LINE_W-1:0] wdata_d, wdata_q, line_d, line_q;
  logic              rd_d, rd_q, wr_d, wr_q;
  logic              iresp_d, iresp_q, dresp_d, dresp_q;

  l1_pmem_arb_fsm #(.RR_ENABLE(RR_ENABLE)) u_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .icache_req (icache_read),
    .dcache_req (dcache_read | dcache_write),
    .l2_resp    (l2_resp),
    .grant_o    (grant),
    .sel_o      (sel),
    .load_o     (load),
    .done_o     (done),
    .busy_o     (busy)
  );

  l1_pmem_arb_checker u_chk (
    .clk          (clk),
    .reset_n      (reset_n),
    .dcache_read  (dcache_read),
    .dcache_write (dcache_write),
    .l2_resp      (l2_resp),
    .l2_busy      (busy)
  );

  // Downstream request registers, returned line and client response pulses
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    line_d  = line_q;
    iresp_d = 1'b0;
    dresp_d = 1'b0;
    if (load) begin
      if (sel == DCACHE) begin
        addr_d  = dcache_address;
        wdata_d = dcache_wdata;
        rd_d    = dcache_read;
        wr_d    = dcache_write;
      end else begin
        addr_d  = icache_address;
        wdata_d = wdata_q;
        rd_d    = 1'b1;
        wr_d    = 1'b0;
      end
    end else if (done) begin
      rd_d = 1'b0;
      wr_d = 1'b0;
      // writes leave the last read line visible on rdata
      if (rd_q) begin
        line_d = l2_rdata;
      end else begin
        line_d = line_q;
      end
      if (grant == DCACHE) begin
        dresp_d = 1'b1;
      end else begin
        iresp_d = 1'b1;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {LINE_W{1'b0}};
      line_q  <= {LINE_W{1'b0}};
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      iresp_q <= 1'b0;
      dresp_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      iresp_q <= iresp_d;
      dresp_q <= dresp_d;
    end
  end

  assign l2_address   = addr_q;
  assign l2_read      = rd_q;
  assign l2_write     = wr_q;
  assign l2_wdata     = wdata_q;
  assign icache_resp  = iresp_q;
  assign dcache_resp  = dresp_q;
  assign icache_rdata = line_q;
  assign dcache_rdata = line_q;
endmodule
